// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_sequencer
// Description : Input-side front end for a small ALU board design. The user
//               sets the switches, then presses one push-button to load each
//               value in turn: operand A, operand B, and the ALU control code.
//               A fourth press returns to operand A entry.
//               The raw button is asynchronous and bouncy. It passes through
//               a 2-FF synchroniser and then a counter-based debouncer. Only
//               the 1->0 transition of the debounced level counts as a press.
// Ports       : i_clk        system clock
//               i_reset      asynchronous reset, active-high
//               i_key_n      raw push-button, active-low, async to i_clk
//               i_switches   operand / control source [N-1:0]
//               o_a          registered operand A [N-1:0]
//               o_b          registered operand B [N-1:0]
//               o_alu_ctrl   registered ALU control code [1:0]
//               o_valid      high while all three values are loaded (SHOW)
//               o_state      current FSM state encoding [1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_sequencer #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_key_n,
    input  logic [N-1:0] i_switches,
    output logic [N-1:0] o_a,
    output logic [N-1:0] o_b,
    output logic [1:0]   o_alu_ctrl,
    output logic         o_valid,
    output logic [1:0]   o_state
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ENTER_A  = 2'd0,
        ST_ENTER_B  = 2'd1,
        ST_ENTER_OP = 2'd2,
        ST_SHOW     = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and debouncer state
    // ------------------------------------------------------------------
    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_w;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [N-1:0]     a_q;
    logic [N-1:0]     a_d;
    logic [N-1:0]     b_q;
    logic [N-1:0]     b_d;
    logic [1:0]       ctrl_q;
    logic [1:0]       ctrl_d;
    logic             valid_q;
    logic             valid_d;

    // The synchroniser and the debounced level idle high, which means
    // "released". A key held through reset therefore goes through the
    // full debounce as a fresh press.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= i_key_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // A new level is accepted only after it has differed from the stable
    // level for DEBOUNCE_CYCLES consecutive cycles. Any return to the
    // stable level clears the partial count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // The press fires in the cycle whose closing edge moves the debounced
    // level from 1 to 0. The FSM then advances on that same edge.
    assign press_w = stable_q & ~stable_d;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    // The switches are sampled only on the advancing edge. The captured
    // values are kept until the next load of the same slot.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (press_w) begin
            case (state_q)
                ST_ENTER_A: begin
                    a_d     = i_switches;
                    state_d = ST_ENTER_B;
                end
                ST_ENTER_B: begin
                    b_d     = i_switches;
                    state_d = ST_ENTER_OP;
                end
                ST_ENTER_OP: begin
                    ctrl_d  = i_switches[1:0];
                    valid_d = 1'b1;
                    state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    valid_d = 1'b0;
                    state_d = ST_ENTER_A;
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = ST_ENTER_A;
                end
            endcase
        end
    end

    assign o_a        = a_q;
    assign o_b        = b_q;
    assign o_alu_ctrl = ctrl_q;
    assign o_valid    = valid_q;
    assign o_state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_sequencer
// Description : Directed self-checking bench for alu_operand_sequencer.
//               It runs with DEBOUNCE_CYCLES=4 and N=4. Inputs change on
//               the falling edge of the clock. Outputs are sampled on the
//               falling edge or 1 time unit after a rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_sequencer;

    localparam int N  = 4;
    localparam int DB = 4;

    logic         clk;
    logic         rst;
    logic         key_n;
    logic [N-1:0] sw;
    logic [N-1:0] o_a;
    logic [N-1:0] o_b;
    logic [1:0]   o_alu_ctrl;
    logic         o_valid;
    logic [1:0]   o_state;

    int errors = 0;
    int checks = 0;

    alu_operand_sequencer #(
        .N               (N),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_key_n    (key_n),
        .i_switches (sw),
        .o_a        (o_a),
        .o_b        (o_b),
        .o_alu_ctrl (o_alu_ctrl),
        .o_valid    (o_valid),
        .o_state    (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A clean press: hold the key low well past the debounce time, then
    // release it and let the release settle.
    task automatic press(input logic [N-1:0] value);
        @(negedge clk);
        sw    = value;
        key_n = 1'b0;
        idle(10);
        key_n = 1'b1;
        idle(10);
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_state); end
        checks++; if (o_a !== 4'h0) begin errors++; $display("FAIL reset_a: got %h expected 0", o_a); end
        checks++; if (o_b !== 4'h0) begin errors++; $display("FAIL reset_b: got %h expected 0", o_b); end
        checks++; if (o_alu_ctrl !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b expected 00", o_alu_ctrl); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        @(negedge clk);
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_load;
        press(4'h3);
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL load_state1: got %0d expected 1", o_state); end
        press(4'h5);
        checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL load_state2: got %0d expected 2", o_state); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL load_valid_op: got %b expected 0", o_valid); end
        press(4'b0010);
        checks++; if (o_a !== 4'h3) begin errors++; $display("FAIL load_a: got %h expected 3", o_a); end
        checks++; if (o_b !== 4'h5) begin errors++; $display("FAIL load_b: got %h expected 5", o_b); end
        checks++; if (o_alu_ctrl !== 2'd2) begin errors++; $display("FAIL load_ctrl: got %0d expected 2", o_alu_ctrl); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL load_valid: got %b expected 1", o_valid); end
        checks++; if (o_state !== 2'd3) begin errors++; $display("FAIL load_state3: got %0d expected 3", o_state); end
        press(4'hE);
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL wrap_state: got %0d expected 0", o_state); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL wrap_valid: got %b expected 0", o_valid); end
        checks++; if (o_a !== 4'h3) begin errors++; $display("FAIL wrap_a_kept: got %h expected 3", o_a); end
        checks++; if (o_b !== 4'h5) begin errors++; $display("FAIL wrap_b_kept: got %h expected 5", o_b); end
        checks++; if (o_alu_ctrl !== 2'd2) begin errors++; $display("FAIL wrap_ctrl_kept: got %0d expected 2", o_alu_ctrl); end
    endtask

    task automatic test_bounce;
        @(negedge clk);
        sw    = 4'h7;
        key_n = 1'b0; idle(3);
        key_n = 1'b1; idle(2);
        key_n = 1'b0; idle(3);
        key_n = 1'b1; idle(10);
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL bounce_no_advance: got %0d expected 0", o_state); end
        // Held press: the first low sample is edge 1, and the advance lands on edge 6.
        key_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL latency_edge5: got %0d expected 0", o_state); end
        @(posedge clk);
        #1;
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL latency_edge6: got %0d expected 1", o_state); end
        checks++; if (o_a !== 4'h7) begin errors++; $display("FAIL latency_a: got %h expected 7", o_a); end
        @(negedge clk);
        key_n = 1'b1;
        idle(10);
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL bounce_release: got %0d expected 1", o_state); end
    endtask

    task automatic test_hold;
        @(negedge clk);
        sw    = 4'hC;
        key_n = 1'b0; idle(100);
        key_n = 1'b1; idle(2);
        key_n = 1'b0; idle(2);
        key_n = 1'b1; idle(2);
        key_n = 1'b0; idle(2);
        key_n = 1'b1; idle(12);
        checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL hold_one_advance: got %0d expected 2", o_state); end
        checks++; if (o_b !== 4'hC) begin errors++; $display("FAIL hold_b: got %h expected C", o_b); end
    endtask

    task automatic test_capture;
        press(4'h1);
        checks++; if (o_alu_ctrl !== 2'd1) begin errors++; $display("FAIL capture_ctrl: got %0d expected 1", o_alu_ctrl); end
        press(4'h0);
        press(4'hA);
        checks++; if (o_a !== 4'hA) begin errors++; $display("FAIL capture_a_load: got %h expected A", o_a); end
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            sw = v[N-1:0];
        end
        idle(2);
        checks++; if (o_a !== 4'hA) begin errors++; $display("FAIL capture_a_held: got %h expected A", o_a); end
        checks++; if (o_b !== 4'hC) begin errors++; $display("FAIL capture_b_held: got %h expected C", o_b); end
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL capture_state: got %0d expected 1", o_state); end
    endtask

    task automatic test_reset_mid_debounce;
        @(negedge clk);
        sw    = 4'h9;
        key_n = 1'b0;
        idle(3);
        rst = 1'b1;
        #1;
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d expected 0", o_state); end
        checks++; if (o_a !== 4'h0) begin errors++; $display("FAIL midrst_a: got %h expected 0", o_a); end
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL midrst_edge5: got %0d expected 0", o_state); end
        @(posedge clk);
        #1;
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL midrst_edge6: got %0d expected 1", o_state); end
        checks++; if (o_a !== 4'h9) begin errors++; $display("FAIL midrst_a_load: got %h expected 9", o_a); end
        @(negedge clk);
        sw = 4'h4;
        idle(20);
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL midrst_single: got %0d expected 1", o_state); end
        checks++; if (o_b !== 4'h0) begin errors++; $display("FAIL midrst_b: got %h expected 0", o_b); end
        key_n = 1'b1;
        idle(10);
    endtask

    initial begin
        rst   = 1'b0;
        key_n = 1'b1;
        sw    = '0;
        test_reset();
        test_load();
        test_bounce();
        test_hold();
        test_capture();
        test_reset_mid_debounce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
